num_sprite_ctrl: RTL
====================

Name: num_sprite_ctrl

Overview:
- Controller for the 64x64 numeric-glyph datapath: sequences a row of NUM_DIGITS digit sprites across the VGA raster and shares one glyph ROM (10 glyphs x 4096 words) between them.
- Per pixel, it decides which digit slot covers (h_cnt, v_cnt) and issues that slot's ROM address. It also delays the hit flag so the flag lines up with ROM data.
- Digit values come from car-control logic through a write/done handshake. They are double-buffered and committed only at a frame boundary, so a displayed number never tears mid-frame.

Parameters:
- X0, 192, left edge (pixels) of digit slot 0; slot i spans X0+64*i .. X0+64*i+63.
- Y0, 208, top edge of all slots; rows Y0 .. Y0+63.
- NUM_DIGITS, 4, number of digit slots (1..4).
- ROM_LAT, 1, glyph ROM read latency in clk cycles (0..3).
- V_COMMIT, 480, v_cnt line on which pending digits are committed.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- h_cnt  in  10  horizontal pixel counter from VGA timing.
- v_cnt  in  10  vertical line counter from VGA timing.
- valid  in  1  active-video flag from VGA timing.
- digit_in  in  16  four 4-bit codes; slot i = digit_in[4i+3:4i]; 0-9 glyph, 10-15 blank.
- digit_we  in  1  one-cycle write strobe for digit_in.
- busy  out  1  a write is pending and not yet committed.
- done  out  1  one-cycle pulse when pending digits become active.
- pixel_addr  out  17  glyph ROM address.
- sprite_hit  out  1  pixel lies inside a non-blank slot; aligned with ROM dout.

Behaviour:
- All state is updated on the rising edge of clk. rst has priority over every other input.
- Reset values:
  - active and pending digit registers = 4'hF per slot (blank).
  - state = IDLE; busy = 0; done = 0.
  - pixel_addr = 0; sprite_hit = 0; hit delay line cleared.
- Address stage (registered, latency 1):
  - dx = h_cnt - X0 and dy = v_cnt - Y0, computed at 11-bit width. A negative result means a miss.
  - slot = dx[7:6]. The pixel is in window when valid=1, 0 <= dx < 64*NUM_DIGITS and 0 <= dy < 64.
  - hit0 = in window AND active code of slot <= 9.
  - On hit0: pixel_addr <= code*4096 + dy[5:0]*64 + dx[5:0]. Maximum value is 40959, which fits in 17 bits.
  - On miss: pixel_addr <= 0.
- Hit alignment: hit0 passes through a ROM_LAT-deep shift register. sprite_hit is therefore valid 1+ROM_LAT cycles after the h_cnt/v_cnt sample that produced it. With ROM_LAT=0, sprite_hit has the same timing as pixel_addr.
- Update FSM:
  - IDLE: digit_we=1 -> pending <= digit_in, go to PENDING, busy=1.
  - PENDING:
    - On the commit condition (v_cnt == V_COMMIT AND h_cnt == 0): active <= pending, done=1 for exactly one cycle, go to IDLE, busy=0.
    - digit_we=1 without the commit condition: pending <= digit_in (latest write wins), stay in PENDING.
  - Simultaneous commit and digit_we in PENDING: the old pending value is committed and done pulses. The new digit_in is captured into pending, state stays PENDING, busy stays 1, and it commits at the next frame.
  - Commit condition while in IDLE: no effect, no done pulse.
  - The commit condition falls outside active video, so active digits never change inside a visible frame.
- Reset mid-operation: a pending write is discarded, the display goes blank, and no done pulse is generated.
- Slots at index >= NUM_DIGITS and unused digit_in nibbles are ignored.

Test Plan:
- Reset, then scan a full frame -> sprite_hit=0 and pixel_addr=0 everywhere; busy=0; done never pulses.
- Write digit_we with digit_in=16'h4321, then run to v=480, h=0 -> busy=1 until the commit. done pulses 1 cycle. At (h=192, v=208), pixel_addr=4096 (slot0 = 1) and sprite_hit=1 after 2 cycles (ROM_LAT=1).
- After committing 16'h0009, sample (h=255, v=271) -> pixel_addr=9*4096+63*64+63=40959. Sample (h=256, v=208) -> slot1 = 0, pixel_addr=0, sprite_hit=1.
- Boundary pixels h=191, h=448, v=207, v=272, and valid=0 inside the window -> sprite_hit=0. Commit code 4'hA in slot2 -> h=320..383 gives sprite_hit=0.
- Write 16'h1111, then write 16'h2222 before commit -> only 2222 is displayed. A write asserted in the commit cycle -> old value committed with done=1, busy stays 1, new value commits next frame.
- Assert rst while PENDING -> busy=0, no done pulse, all slots blank on the following frame.

Source files
------------

// File: rtl/num_sprite_ctrl_if.sv
// Raster/handshake bundle between VGA timing, car-control logic and the
// numeric-glyph sprite controller.
interface num_sprite_ctrl_if;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic [15:0] digit_in;
  logic        digit_we;
  logic        busy;
  logic        done;
  logic [16:0] pixel_addr;
  logic        sprite_hit;

  modport master (
    output h_cnt, v_cnt, valid, digit_in, digit_we,
    input  busy, done, pixel_addr, sprite_hit
  );

  modport slave (
    input  h_cnt, v_cnt, valid, digit_in, digit_we,
    output busy, done, pixel_addr, sprite_hit
  );
endinterface

// File: rtl/num_sprite_ctrl.sv
// Sequences a row of 64x64 digit sprites over the raster, sharing one glyph ROM,
// with frame-boundary double-buffered digit updates.
module num_sprite_ctrl #(
  parameter int unsigned X0         = 192,
  parameter int unsigned Y0         = 208,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned V_COMMIT   = 480
) (
  input  logic              clk,
  input  logic              rst,
  num_sprite_ctrl_if.slave  bus
);

  localparam int unsigned CW    = 10;
  localparam int unsigned XW    = 11;
  localparam int unsigned AW    = 17;
  localparam int unsigned DW    = 16;
  localparam int unsigned WIN_W = 64 * NUM_DIGITS;

  typedef enum logic {IDLE, PENDING} state_t;

  state_t          state_q;
  logic [DW-1:0]   pending_q;
  logic [DW-1:0]   active_q;
  logic            busy_q;
  logic            done_q;
  logic [AW-1:0]   addr_q;
  logic [ROM_LAT:0] hit_q;

  logic [XW-1:0]   dx_c;
  logic [XW-1:0]   dy_c;
  logic [3:0]      code_c;
  logic            in_win_c;
  logic            hit0_c;
  logic            commit_c;

  // Offsets are taken at 11 bits so a pixel left of / above the row goes negative.
  assign dx_c = XW'(bus.h_cnt) - XW'(X0);
  assign dy_c = XW'(bus.v_cnt) - XW'(Y0);

  assign code_c   = active_q[{dx_c[7:6], 2'b00} +: 4];
  assign in_win_c = bus.valid
                  && !dx_c[XW-1] && (dx_c < XW'(WIN_W))
                  && !dy_c[XW-1] && (dy_c < XW'(64));
  assign hit0_c   = in_win_c && (code_c <= 4'd9);
  assign commit_c = (bus.v_cnt == CW'(V_COMMIT)) && (bus.h_cnt == CW'(0));

  // Address stage and hit delay line aligning the flag with ROM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      hit_q  <= '0;
    end else begin
      if (hit0_c) addr_q <= AW'({code_c, dy_c[5:0], dx_c[5:0]});
      else        addr_q <= '0;
      hit_q[0] <= hit0_c;
      for (int unsigned i = 1; i <= ROM_LAT; i++) begin
        hit_q[i] <= hit_q[i-1];
      end
    end
  end

  // Digit update FSM: a write waits in pending until the commit line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '1;
      active_q  <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.digit_we) begin
            pending_q <= bus.digit_in;
            state_q   <= PENDING;
            busy_q    <= 1'b1;
          end
        end
        PENDING: begin
          if (commit_c) begin
            active_q <= pending_q;
            done_q   <= 1'b1;
            // A write landing on the commit cycle is held for the next frame.
            if (bus.digit_we) begin
              pending_q <= bus.digit_in;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (bus.digit_we) begin
            pending_q <= bus.digit_in;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pixel_addr = addr_q;
  assign bus.sprite_hit = hit_q[ROM_LAT];

endmodule
